note_player: RTL

Downstream consumer of `song_reader`. Accepts one note per `new_note` pulse, generates a square-wave tone at the pitch given by the 6-bit note number, and counts the note's duration in beats. When the duration expires it returns a single-cycle `note_done` pulse, which advances `song_reader` to the next note. `play` pauses the tone and the duration count without losing position.

---
 rtl/note_player.sv | 88 ++++++++
 1 files changed

// File: rtl/note_player.sv
// note_player: plays one note as a square-wave tone for a number of beats,
// then pulses note_done; play=0 freezes tone and duration without losing position.
module note_player #(
   parameter int BEAT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       play,
   input  logic [5:0] note,
   input  logic [5:0] duration,
   input  logic       new_note,
   output logic       note_done,
   output logic       tone_out,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_t;
   state_t      state;
   logic [5:0]  note_reg, beats_left, k, rem;
   logic [2:0]  oct;
   logic [8:0]  base;
   logic [15:0] beat_cnt, tone_cnt, half_period;
   // note n -> k=n-1 split into octave (k/12) and semitone (k%12)
   always_comb begin
      k    = note_reg - 6'd1;
      oct  = k >= 6'd60 ? 3'd5 : k >= 6'd48 ? 3'd4 : k >= 6'd36 ? 3'd3 :
             k >= 6'd24 ? 3'd2 : k >= 6'd12 ? 3'd1 : 3'd0;
      rem  = k - ({3'b0, oct} << 3) - ({3'b0, oct} << 2);
      base = rem == 6'd0  ? 9'd478 : rem == 6'd1  ? 9'd451 : rem == 6'd2 ? 9'd426 :
             rem == 6'd3  ? 9'd402 : rem == 6'd4  ? 9'd379 : rem == 6'd5 ? 9'd358 :
             rem == 6'd6  ? 9'd338 : rem == 6'd7  ? 9'd319 : rem == 6'd8 ? 9'd301 :
             rem == 6'd9  ? 9'd284 : rem == 6'd10 ? 9'd268 : 9'd253;
      half_period = 16'(base) << (3'd5 - oct);
   end
   assign busy = (state == PLAYING);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         note_reg   <= '0;
         beats_left <= '0;
         beat_cnt   <= '0;
         tone_cnt   <= '0;
         tone_out   <= 1'b0;
         note_done  <= 1'b0;
      end else if (new_note) begin
         state      <= PLAYING;
         note_reg   <= note;
         beats_left <= duration;
         beat_cnt   <= '0;
         tone_cnt   <= '0;
         tone_out   <= 1'b0;
         note_done  <= 1'b0;
      end else begin
         case (state)
            PLAYING: begin
               if (beats_left == 6'd0) begin
                  state     <= DONE;
                  note_done <= 1'b1;
                  tone_out  <= 1'b0;
               end else if (play) begin
                  if (note_reg != 6'd0) begin
                     if (tone_cnt == half_period - 16'd1) begin
                        tone_cnt <= '0;
                        tone_out <= ~tone_out;
                     end else
                        tone_cnt <= tone_cnt + 16'd1;
                  end
                  if (beat_cnt == 16'(BEAT_CYCLES - 1)) begin
                     beat_cnt   <= '0;
                     beats_left <= beats_left - 6'd1;
                     // last beat elapsed: finishing overrides any tone toggle above
                     if (beats_left == 6'd1) begin
                        state     <= DONE;
                        note_done <= 1'b1;
                        tone_out  <= 1'b0;
                     end
                  end else
                     beat_cnt <= beat_cnt + 16'd1;
               end
            end
            DONE: begin
               state     <= IDLE;
               note_done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
